osd_cmd_sequencer: RTL and testbench

- Upstream feeder for the OSD overlay's command/write port, in the clk_sys domain.
- Accepts 16-bit command/data words as a valid/ready stream with a packet-end marker and buffers them in a small FIFO.
- Replays each packet onto the OSD bus: io_osd framing, a strobe edge per word, and a guaranteed io_osd-low gap between packets. The OSD latches enable/disable during that gap.

---
 rtl/osd_cmd_sequencer_if.sv | 14 +
 rtl/osd_cmd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_osd_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_cmd_sequencer_if.sv
// Upstream command/data word stream into osd_cmd_sequencer.
//   s_valid : word valid (master -> slave)
//   s_ready : slave can accept a word (slave -> master)
//   s_data  : 16-bit word; first word of a packet carries the command in [7:0]
//   s_last  : final word of a packet
interface osd_cmd_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/osd_cmd_sequencer.sv
// OSD command sequencer: buffers a valid/ready word stream in a FIFO and
// replays each packet onto the OSD bus with io_osd framing, one io_strobe
// pulse per word and a guaranteed io_osd-low gap between packets.
//
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   s_if (slave)     : s_valid/s_ready/s_data/s_last input stream
//   io_osd           : packet frame
//   io_strobe        : word strobe, OSD samples on its rising edge
//   io_din           : word presented to the OSD
//   busy             : FSM active or FIFO non-empty
//   pkt_done         : one-cycle pulse at packet completion
//   pkt_abort        : one-cycle pulse on starvation timeout
//
// Optional feature (macro OSD_CMD_TIMEOUT_EN): mid-packet starvation timeout
// that aborts the packet and drops its remaining words. Without the macro,
// pkt_abort is tied low and the sequencer waits indefinitely.
module osd_cmd_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    osd_cmd_sequencer_if.slave  s_if,
    output logic                io_osd,
    output logic                io_strobe,
    output logic [15:0]         io_din,
    output logic                busy,
    output logic                pkt_done,
    output logic                pkt_abort
);

    localparam int unsigned DW = 16;
    localparam int unsigned EW = DW + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic            s_ready_q;
    logic            cur_last;
    logic            empty_c, full_n_c, push_c, pop_c, load_c, done_c;
    logic            expired_c, timeout_c, dropping_c;
    logic [EW-1:0]   head_c;

    assign s_if.s_ready = s_ready_q;

    // FIFO bookkeeping; extra pointer bit distinguishes full from empty
    assign push_c   = s_if.s_valid & s_ready_q;
    assign empty_c  = (wr_ptr == rd_ptr);
    assign head_c   = mem[rd_ptr[AW-1:0]];
    assign wr_ptr_n = wr_ptr + PW'(push_c);
    assign rd_ptr_n = rd_ptr + PW'(pop_c);
    assign full_n_c = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    // FIFO storage, contents discarded on reset by clearing the pointers
    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= {s_if.s_last, s_if.s_data};
        end
    end

    // Shared phase counter: strobe high/low minimum, or gap length
    assign expired_c = (cnt == CW'(STROBE_CYC - 1));

    // Next-state logic; pop happens on entry to LOAD so io_din leads the strobe
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop_c   = 1'b0;
        load_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!empty_c) begin
                    pop_c = 1'b1;
                    if (!dropping_c) begin
                        state_n = ST_LOAD;
                        load_c  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_n = ST_HIGH;
                cnt_n   = '0;
            end
            ST_HIGH: begin
                if (expired_c) begin
                    state_n = ST_LOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_LOW: begin
                if (!expired_c) begin
                    cnt_n = cnt + CW'(1);
                end else if (cur_last) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                    done_c  = 1'b1;
                end else if (!empty_c) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                    pop_c   = 1'b1;
                    load_c  = 1'b1;
                end else if (timeout_c) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, FIFO pointers and registered outputs (decoded from next state)
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s_ready_q <= 1'b0;
            cur_last  <= 1'b0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            s_ready_q <= !full_n_c;
            io_osd    <= (state_n == ST_LOAD) || (state_n == ST_HIGH) ||
                         (state_n == ST_LOW);
            io_strobe <= (state_n == ST_HIGH);
            busy      <= (state_n != ST_IDLE) || (wr_ptr_n != rd_ptr_n);
            pkt_done  <= done_c;
            if (load_c) begin
                io_din   <= head_c[DW-1:0];
                cur_last <= head_c[DW];
            end
        end
    end

`ifdef OSD_CMD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt;
    logic          drop;
    logic          starve_c;

    // Starvation: minimum low time served, packet not finished, nothing queued
    assign starve_c   = (state == ST_LOW) && expired_c && !cur_last && empty_c;
    assign timeout_c  = starve_c && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign dropping_c = drop;

    // Timeout counter and drop flag; drop clears once the aborted packet's last word is popped
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tcnt      <= '0;
            drop      <= 1'b0;
            pkt_abort <= 1'b0;
        end else begin
            tcnt      <= (starve_c && !timeout_c) ? tcnt + TW'(1) : '0;
            pkt_abort <= timeout_c;
            if (timeout_c) begin
                drop <= 1'b1;
            end else if (drop && (state == ST_IDLE) && !empty_c && head_c[DW]) begin
                drop <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_timeout_c;

    assign timeout_c        = 1'b0;
    assign dropping_c       = 1'b0;
    assign pkt_abort        = 1'b0;
    assign unused_timeout_c = 32'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_osd_cmd_sequencer.sv
// Bench for osd_cmd_sequencer: vector table, corner-case sequences and a
// randomized run scored against a word-order scoreboard and bus-timing rules.
module tb_osd_cmd_sequencer;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned STROBE_CYC  = 2;
    localparam int unsigned GAP_CYC     = 4;
    localparam int unsigned TIMEOUT_CYC = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_osd, io_strobe, busy, pkt_done, pkt_abort;
    logic [15:0] io_din;

    osd_cmd_sequencer_if bus ();

    osd_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .STROBE_CYC  (STROBE_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .s_if      (bus),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .pkt_abort (pkt_abort)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } word_t;

    typedef struct {
        int              len;
        logic [3:0][15:0] w;
        int              lat;
        int              osd_hi;
        int              period;
    } vec_t;

    word_t exp_q[$];
    int    rise_hist[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;

    // monitor state
    logic        p_osd = 1'b0, p_strobe = 1'b0;
    logic [15:0] p_din = '0;
    int s_hi = 0, osd_hi = 0, low_len = 0, osd_len = 0, last_low = 0;
    bit gap_armed = 1'b0;
    int n_rise = 0, n_osd_rise = 0, n_done = 0, n_abort = 0, exp_done = 0;
    int osd_rise_cyc = 0;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Bus monitor: scoreboard on strobe rises plus framing/timing rules
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            p_osd     = 1'b0;
            p_strobe  = 1'b0;
            p_din     = '0;
            s_hi      = 0;
            osd_hi    = 0;
            low_len   = 0;
            gap_armed = 1'b0;
        end else begin
            if (io_strobe) check("strobe_without_osd", int'(io_osd), 1);
            if (io_strobe && !p_strobe) begin
                n_rise++;
                rise_hist.push_back(cyc);
                check("din_setup", int'(io_din), int'(p_din));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", int'(io_din), -1);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("din_at_strobe", int'(io_din), int'(e.data));
                    if (e.last) exp_done++;
                end
                s_hi = 1;
            end else if (io_strobe) begin
                s_hi++;
            end else if (p_strobe) begin
                check("strobe_high_len", s_hi, STROBE_CYC);
            end
            if (io_osd && !p_osd) begin
                n_osd_rise++;
                osd_rise_cyc = cyc;
                last_low = low_len;
                if (gap_armed) check("gap_min_len", int'(low_len >= GAP_CYC + 1), 1);
                gap_armed = 1'b0;
                osd_hi = 1;
            end else if (io_osd) begin
                osd_hi++;
            end
            if (!io_osd && p_osd) begin
                check("osd_fall_during_strobe", int'(p_strobe), 0);
                osd_len = osd_hi;
                gap_armed = 1'b1;
                low_len = 1;
            end else if (!io_osd) begin
                low_len++;
            end
            if (pkt_done) n_done++;
            if (pkt_abort) n_abort++;
            p_osd    = io_osd;
            p_strobe = io_strobe;
            p_din    = io_din;
        end
    end

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    // Offer one word; returns cycles spent waiting and the cycle it was offered
    task automatic push(input logic [15:0] d, input logic l, input bit expect_out,
                        output int waited, output int t_acc);
        word_t e;
        waited = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && waited < 300) begin
            step();
            waited++;
        end
        check("push_accept", int'(bus.s_ready), 1);
        e.last = l;
        e.data = d;
        if (expect_out && bus.s_ready) exp_q.push_back(e);
        t_acc = cyc;
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!busy) break;
        end
        check("reach_idle", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[4];
        int   w, t, t0, t1, d0, r0, o0, a0, first_wait, pkts, len;

        vec[0] = '{len: 3, w: {16'h0000, 16'h0055, 16'h00AA, 16'h0021}, lat: 2, osd_hi: 15, period: 5};
        vec[1] = '{len: 1, w: {16'h0000, 16'h0000, 16'h0000, 16'h0041}, lat: 2, osd_hi: 5,  period: 0};
        vec[2] = '{len: 2, w: {16'h0000, 16'h0000, 16'hBEEF, 16'h1234}, lat: 2, osd_hi: 10, period: 5};
        vec[3] = '{len: 4, w: {16'h7FFE, 16'h8001, 16'h0000, 16'hFFFF}, lat: 2, osd_hi: 20, period: 5};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // reset values
        step();
        step();
        check("rst_io_osd", int'(io_osd), 0);
        check("rst_io_strobe", int'(io_strobe), 0);
        check("rst_io_din", int'(io_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_pkt_abort", int'(pkt_abort), 0);
        reset_n = 1'b1;
        step();
        check("ready_after_release", int'(bus.s_ready), 1);

        // vector table: back-to-back packets into an idle sequencer
        for (int v = 0; v < 4; v++) begin
            d0 = n_done;
            r0 = n_rise;
            t0 = 0;
            for (int i = 0; i < vec[v].len; i++) begin
                push(vec[v].w[i], logic'(i == vec[v].len - 1), 1'b1, w, t);
                if (i == 0) t0 = t;
            end
            wait_idle();
            check($sformatf("vec%0d_latency", v), osd_rise_cyc - t0, vec[v].lat);
            check($sformatf("vec%0d_osd_high", v), osd_len, vec[v].osd_hi);
            check($sformatf("vec%0d_strobes", v), n_rise - r0, vec[v].len);
            check($sformatf("vec%0d_done", v), n_done - d0, 1);
            if (vec[v].len > 1)
                check($sformatf("vec%0d_period", v), rise_hist[$] - rise_hist[$-1], vec[v].period);
        end

        // single word, then next packet pushed during the gap
        d0 = n_done;
        push(16'h0041, 1'b1, 1'b1, w, t);
        for (int i = 0; i < 100 && n_done == d0; i++) step();
        check("gap_done_seen", n_done - d0, 1);
        push(16'h0040, 1'b1, 1'b1, w, t);
        wait_idle();
        check("gap_low_len", last_low, GAP_CYC + 1);
        check("gap_two_done", n_done - d0, 2);

        // 40-word packet with s_valid held: fill, backpressure, pointer wrap
        r0 = n_rise;
        first_wait = -1;
        for (int i = 0; i < 40; i++) begin
            push(16'(16'h0A00 + i), logic'(i == 39), 1'b1, w, t);
            if (w > 0 && first_wait < 0) first_wait = i;
        end
        wait_idle();
        check("fill_words_before_stall", first_wait, 20);
        check("fill_strobes", n_rise - r0, 40);
        check("fill_queue_empty", exp_q.size(), 0);

`ifdef OSD_CMD_TIMEOUT_EN
        // starvation timeout: abort, drop rest of packet, next packet normal
        d0 = n_done;
        r0 = n_rise;
        o0 = n_osd_rise;
        a0 = n_abort;
        push(16'h0020, 1'b0, 1'b1, w, t);
        repeat (20) step();
        push(16'h0033, 1'b0, 1'b0, w, t);
        push(16'h0044, 1'b1, 1'b0, w, t);
        push(16'h0041, 1'b1, 1'b1, w, t);
        wait_idle();
        check("to_abort_pulses", n_abort - a0, 1);
        check("to_done_pulses", n_done - d0, 1);
        check("to_strobes", n_rise - r0, 2);
        check("to_osd_frames", n_osd_rise - o0, 2);
`else
        // starvation without timeout: frame held, no abort
        d0 = n_done;
        r0 = n_rise;
        o0 = n_osd_rise;
        a0 = n_abort;
        push(16'h0020, 1'b0, 1'b1, w, t);
        repeat (50) step();
        check("starve_osd_held", int'(io_osd), 1);
        push(16'h0011, 1'b0, 1'b1, w, t1);
        push(16'h0022, 1'b1, 1'b1, w, t);
        wait_idle();
        check("starve_one_frame", n_osd_rise - o0, 1);
        check("starve_resume_delay", rise_hist[r0 + 1] - t1, 3);
        check("starve_strobes", n_rise - r0, 3);
        check("starve_no_abort", n_abort - a0, 0);
        check("starve_done", n_done - d0, 1);
`endif

        // reset during HIGH of the second word
        r0 = n_rise;
        push(16'h0101, 1'b0, 1'b1, w, t);
        push(16'h0202, 1'b0, 1'b1, w, t);
        for (int i = 0; i < 100 && n_rise < r0 + 2; i++) step();
        check("rst_mid_second_rise", n_rise - r0, 2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_io_osd", int'(io_osd), 0);
        check("rst_mid_io_strobe", int'(io_strobe), 0);
        check("rst_mid_io_din", int'(io_din), 0);
        check("rst_mid_busy", int'(busy), 0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        step();
        check("rst_mid_ready", int'(bus.s_ready), 1);
        check("rst_mid_empty", int'(busy), 0);
        d0 = n_done;
        push(16'h0303, 1'b1, 1'b1, w, t);
        wait_idle();
        check("rst_mid_recover", n_done - d0, 1);

        // randomized packets against the scoreboard
        d0 = n_done;
        a0 = n_abort;
        pkts = 40;
        for (int p = 0; p < pkts; p++) begin
            len = int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                push(16'($urandom), logic'(i == len - 1), 1'b1, w, t);
                repeat ($urandom_range(0, 2)) step();
            end
            repeat ($urandom_range(0, 6)) step();
        end
        wait_idle();
        check("rand_done_count", n_done - d0, pkts);
        check("rand_no_abort", n_abort - a0, 0);
        check("rand_queue_empty", exp_q.size(), 0);
        check("total_done", n_done, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
